data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 34 +++
 rtl/dmem_sat_counter.sv | 41 ++++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared memory parameters and access-classification helpers used by the
// data memory responder and the core that talks to it.
package data_mem_responder_pkg;

    localparam int DMEM_DEPTH     = 256;
    localparam int DMEM_ADDR_BITS = 8;
    localparam int DMEM_WORD_W    = 64;
    localparam int DMEM_CNT_W     = 16;

    // What a core request does on this edge.
    typedef enum logic [2:0] {
        ACC_IDLE   = 3'd0,
        ACC_READ   = 3'd1,
        ACC_WRITE  = 3'd2,
        ACC_OOR_RD = 3'd3,
        ACC_OOR_WR = 3'd4
    } acc_kind_e;

    // Classify one core request. memWrEn is ignored unless the request is valid.
    function automatic acc_kind_e classify_access(input logic en,
                                                  input logic wr,
                                                  input logic oor);
        acc_kind_e kind;
        if (!en) begin
            kind = ACC_IDLE;
        end else if (oor) begin
            kind = wr ? ACC_OOR_WR : ACC_OOR_RD;
        end else begin
            kind = wr ? ACC_WRITE : ACC_READ;
        end
        return kind;
    endfunction

endpackage

// File: rtl/dmem_sat_counter.sv
// 16-bit access counter: synchronous clear beats increment, and the count
// sticks at all-ones instead of wrapping.
module dmem_sat_counter
    import data_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    output logic [DMEM_CNT_W-1:0] count
);

    localparam logic [DMEM_CNT_W-1:0] CNT_MAX = {DMEM_CNT_W{1'b1}};

    logic [DMEM_CNT_W-1:0] count_r;
    logic [DMEM_CNT_W-1:0] count_next_s;

    // Next count: clear has priority, increment stops at the ceiling.
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = {DMEM_CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_next_s = count_r + DMEM_CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {DMEM_CNT_W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/data_mem_responder.sv
// Single-port 64-bit data memory seen by the core, with a side preload port,
// registered read data, a sticky out-of-range flag and saturating access
// counters.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int ADDR_BITS = DMEM_ADDR_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memEn,
    input  logic                   memWrEn,
    input  logic [0:31]            memAddr,
    input  logic [0:63]            dataOut,
    output logic [0:63]            dataIn,
    input  logic                   ld_en,
    input  logic [0:ADDR_BITS-1]   ld_addr,
    input  logic [0:63]            ld_data,
    input  logic                   clr_cnt,
    output logic                   err_oor,
    output logic [0:15]            rd_cnt,
    output logic [0:15]            wr_cnt
);

    // Bit 0 of the big-endian ports is the MSB, so plain vector copies keep
    // numeric values intact.
    logic [31:0]             addr_s;
    logic [ADDR_BITS-1:0]    idx_s;
    logic [ADDR_BITS-1:0]    ld_idx_s;
    logic [DMEM_WORD_W-1:0]  wdata_s;
    logic [DMEM_WORD_W-1:0]  ld_data_s;
    logic                    oor_s;
    acc_kind_e               kind_s;

    logic [DMEM_WORD_W-1:0]  mem_r [DEPTH];
    logic [DMEM_WORD_W-1:0]  data_r;
    logic [DMEM_WORD_W-1:0]  data_next_s;
    logic                    err_r;
    logic                    err_next_s;
    logic                    mem_we_s;
    logic                    rd_inc_s;
    logic                    wr_inc_s;
    logic [DMEM_CNT_W-1:0]   rd_cnt_s;
    logic [DMEM_CNT_W-1:0]   wr_cnt_s;

    assign addr_s    = memAddr;
    assign idx_s     = addr_s[ADDR_BITS-1:0];
    assign ld_idx_s  = ld_addr;
    assign wdata_s   = dataOut;
    assign ld_data_s = ld_data;
    assign oor_s     = (addr_s >= 32'(DEPTH));
    assign kind_s    = classify_access(memEn, memWrEn, oor_s);

    // Decode the request into write strobe, counter bumps, next read data and error.
    always_comb begin
        mem_we_s    = 1'b0;
        rd_inc_s    = 1'b0;
        wr_inc_s    = 1'b0;
        data_next_s = data_r;
        err_next_s  = err_r;
        case (kind_s)
            ACC_READ: begin
                rd_inc_s    = 1'b1;
                data_next_s = mem_r[idx_s];
            end
            ACC_WRITE: begin
                wr_inc_s = 1'b1;
                mem_we_s = 1'b1;
            end
            ACC_OOR_RD: begin
                data_next_s = {DMEM_WORD_W{1'b0}};
                err_next_s  = 1'b1;
            end
            ACC_OOR_WR: begin
                err_next_s = 1'b1;
            end
            ACC_IDLE: begin
                data_next_s = data_r;
            end
            default: begin
                data_next_s = data_r;
                err_next_s  = err_r;
            end
        endcase
    end

    // Memory array: preload first, core write last so the core wins on a
    // shared address; nothing commits on an edge that sees reset low.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (ld_en) begin
                mem_r[ld_idx_s] <= ld_data_s;
            end
            if (mem_we_s) begin
                mem_r[idx_s] <= wdata_s;
            end
        end
    end

    // Read data and sticky error flag, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r <= {DMEM_WORD_W{1'b0}};
            err_r  <= 1'b0;
        end else begin
            data_r <= data_next_s;
            err_r  <= err_next_s;
        end
    end

    dmem_sat_counter u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (rd_inc_s),
        .count (rd_cnt_s)
    );

    dmem_sat_counter u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (wr_inc_s),
        .count (wr_cnt_s)
    );

    assign dataIn  = data_r;
    assign err_oor = err_r;
    assign rd_cnt  = rd_cnt_s;
    assign wr_cnt  = wr_cnt_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset-abort sequence,
// randomized traffic against a behavioural model, and counter saturation.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        memEn;
    logic        memWrEn;
    logic [0:31] memAddr;
    logic [0:63] dataOut;
    logic [0:63] dataIn;
    logic        ld_en;
    logic [0:7]  ld_addr;
    logic [0:63] ld_data;
    logic        clr_cnt;
    logic        err_oor;
    logic [0:15] rd_cnt;
    logic [0:15] wr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk     (clk),
        .reset   (reset),
        .memEn   (memEn),
        .memWrEn (memWrEn),
        .memAddr (memAddr),
        .dataOut (dataOut),
        .dataIn  (dataIn),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .clr_cnt (clr_cnt),
        .err_oor (err_oor),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt)
    );

    typedef struct {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [63:0] wd;
        logic        ld;
        logic [7:0]  la;
        logic [63:0] ldd;
        logic        clr;
        logic [63:0] e_data;
        logic [15:0] e_rd;
        logic [15:0] e_wr;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    // Behavioural model state for the random phase.
    logic [63:0] m_mem [256];
    logic [63:0] m_data;
    int          m_rd;
    int          m_wr;
    logic        m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] d, input int rd,
                             input int wr, input logic e);
        check({tag, ".dataIn"}, 64'(dataIn), d);
        check({tag, ".rd_cnt"}, 64'(rd_cnt), 64'(rd));
        check({tag, ".wr_cnt"}, 64'(wr_cnt), 64'(wr));
        check({tag, ".err_oor"}, 64'(err_oor), 64'(e));
    endtask

    task automatic idle();
        memEn   = 1'b0;
        memWrEn = 1'b0;
        memAddr = 32'd0;
        dataOut = 64'd0;
        ld_en   = 1'b0;
        ld_addr = 8'd0;
        ld_data = 64'd0;
        clr_cnt = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [63:0] dead;
        logic        inr;
        dead = 64'hDEAD_BEEF_0123_4567;

        //            en    we    addr            wd          ld    la    ld data     clr   data        rd      wr      err
        vecs[0]  = '{1'b0, 1'b0, 32'd0,          64'd0,      1'b1, 8'd3, dead,       1'b0, 64'd0,      16'd0,  16'd0,  1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'd3,          64'd0,      1'b0, 8'd0, 64'd0,      1'b0, dead,       16'd1,  16'd0,  1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'd5,          64'h1,      1'b0, 8'd0, 64'd0,      1'b0, dead,       16'd1,  16'd1,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'd5,          64'd0,      1'b0, 8'd0, 64'd0,      1'b0, 64'h1,      16'd2,  16'd1,  1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'd7,          64'hAA,     1'b1, 8'd7, 64'hBB,     1'b0, 64'h1,      16'd2,  16'd2,  1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'd7,          64'd0,      1'b0, 8'd0, 64'd0,      1'b0, 64'hAA,     16'd3,  16'd2,  1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'd0,          64'd0,      1'b1, 8'd9, 64'h11,     1'b0, 64'hAA,     16'd3,  16'd2,  1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'd9,          64'd0,      1'b1, 8'd9, 64'h22,     1'b0, 64'h11,     16'd4,  16'd2,  1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'd9,          64'd0,      1'b0, 8'd0, 64'd0,      1'b0, 64'h22,     16'd5,  16'd2,  1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'd10,         64'h33,     1'b1, 8'd11, 64'h44,    1'b0, 64'h22,     16'd5,  16'd3,  1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'd10,         64'd0,      1'b0, 8'd0, 64'd0,      1'b0, 64'h33,     16'd6,  16'd3,  1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'd11,         64'd0,      1'b0, 8'd0, 64'd0,      1'b0, 64'h44,     16'd7,  16'd3,  1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'd10,         64'hFF,     1'b0, 8'd0, 64'd0,      1'b0, 64'h44,     16'd7,  16'd3,  1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'd10,         64'd0,      1'b0, 8'd0, 64'd0,      1'b0, 64'h33,     16'd8,  16'd3,  1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'd0,          64'd0,      1'b1, 8'd0, 64'h77,     1'b1, 64'h33,     16'd0,  16'd0,  1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'h0000_0100,  64'd0,      1'b0, 8'd0, 64'd0,      1'b0, 64'd0,      16'd0,  16'd0,  1'b1};
        vecs[16] = '{1'b1, 1'b1, 32'h8000_0000,  64'h99,     1'b0, 8'd0, 64'd0,      1'b0, 64'd0,      16'd0,  16'd0,  1'b1};
        vecs[17] = '{1'b1, 1'b0, 32'd3,          64'd0,      1'b0, 8'd0, 64'd0,      1'b0, dead,       16'd1,  16'd0,  1'b1};
        vecs[18] = '{1'b1, 1'b1, 32'h0000_0100,  64'h99,     1'b0, 8'd0, 64'd0,      1'b0, dead,       16'd1,  16'd0,  1'b1};
        vecs[19] = '{1'b1, 1'b0, 32'd0,          64'd0,      1'b0, 8'd0, 64'd0,      1'b0, 64'h77,     16'd2,  16'd0,  1'b1};

        // Reset state
        idle();
        reset = 1'b0;
        #12;
        check_all("reset", 64'd0, 0, 0, 1'b0);
        #5;
        reset = 1'b1;

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            memEn   = vecs[i].en;
            memWrEn = vecs[i].we;
            memAddr = vecs[i].addr;
            dataOut = vecs[i].wd;
            ld_en   = vecs[i].ld;
            ld_addr = vecs[i].la;
            ld_data = vecs[i].ldd;
            clr_cnt = vecs[i].clr;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_data, int'(vecs[i].e_rd),
                      int'(vecs[i].e_wr), vecs[i].e_err);
        end

        // Reset dropped between edges with a write pending: outputs clear at
        // once and the write never lands.
        memEn   = 1'b1;
        memWrEn = 1'b1;
        memAddr = 32'd5;
        dataOut = 64'hCAFE;
        #3;
        reset = 1'b0;
        #1;
        check_all("async_rst", 64'd0, 0, 0, 1'b0);
        step();
        idle();
        memEn   = 1'b1;
        memAddr = 32'd5;
        #2;
        reset = 1'b1;
        step();
        check_all("post_rst_read", 64'h1, 1, 0, 1'b0);

        // Random traffic against the behavioural model
        idle();
        m_data = 64'h1;
        m_rd   = 1;
        m_wr   = 0;
        m_err  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ld_en   = 1'b1;
            ld_addr = 8'(i);
            ld_data = {$urandom(), $urandom()};
            m_mem[i] = ld_data;
            step();
        end
        for (int i = 0; i < 2000; i++) begin
            memEn   = ($urandom_range(0, 99) < 70);
            memWrEn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 2) a = $urandom() | 32'h0000_0100;
            else a = 32'($urandom_range(0, 255));
            memAddr = a;
            dataOut = {$urandom(), $urandom()};
            ld_en   = ($urandom_range(0, 99) < 30);
            ld_addr = ($urandom_range(0, 1) == 0) ? a[7:0] : 8'($urandom_range(0, 255));
            ld_data = {$urandom(), $urandom()};
            clr_cnt = ($urandom_range(0, 99) < 2);

            inr = (a < 32'd256);
            if (memEn && !memWrEn) m_data = inr ? m_mem[a[7:0]] : 64'd0;
            if (memEn && !inr) m_err = 1'b1;
            if (ld_en) m_mem[ld_addr] = ld_data;
            if (memEn && memWrEn && inr) m_mem[a[7:0]] = dataOut;
            if (clr_cnt) begin
                m_rd = 0;
                m_wr = 0;
            end else begin
                if (memEn && !memWrEn && inr && m_rd < 65535) m_rd = m_rd + 1;
                if (memEn && memWrEn && inr && m_wr < 65535) m_wr = m_wr + 1;
            end
            step();
            check_all($sformatf("rand%0d", i), m_data, m_rd, m_wr, m_err);
        end

        // Read counter saturation and clear-over-increment
        idle();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        memEn   = 1'b1;
        memAddr = 32'd0;
        repeat (65534) step();
        check("sat.rd_cnt_fffe", 64'(rd_cnt), 64'hFFFE);
        step();
        check("sat.rd_cnt_ffff", 64'(rd_cnt), 64'hFFFF);
        step();
        check("sat.rd_cnt_hold", 64'(rd_cnt), 64'hFFFF);
        check("sat.dataIn", 64'(dataIn), m_mem[0]);
        check("sat.wr_cnt", 64'(wr_cnt), 64'd0);
        clr_cnt = 1'b1;
        step();
        check("sat.clr_wins", 64'(rd_cnt), 64'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
